// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
// Shared definitions for the fetch unit and the 8-bit instruction decoder:
// instruction width, opcode field position, opcode constants and the fetch
// FSM state encoding.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam int INSTR_W    = 8;
  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 4;

  // Control-flow opcodes (instruction bits 7:4)
  localparam logic [3:0] OP_J   = 4'b1000;
  localparam logic [3:0] OP_JAL = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // request pending or in progress
    ST_ISSUE = 2'd1,  // instruction presented to the decoder
    ST_FLUSH = 2'd2   // waiting out a request made stale by a redirect
  } fetch_state_e;

  function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch sequencer: owns the PC, reads instruction memory over a req/ack
// handshake and hands each instruction to the decoder over valid/ready.
// A redirect (taken branch/jump) loads the PC; a request already on the
// memory bus is held until acked and its data is discarded.
//
// Ports
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   imem_req/addr      read request and address to instruction memory
//   imem_ack/rdata     memory completion and returned instruction
//   instr_valid        instruction/instr_pc valid for the decoder
//   instruction        fetched instruction
//   instr_pc           address of the presented instruction
//   instr_ready        decoder accepts the presented instruction
//   redirect/target    taken branch or jump, new PC
// All outputs are registered.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               imem_req_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instruction_q;
  logic [ADDR_W-1:0]  instr_pc_q;

  logic [ADDR_W-1:0]  pc_plus1_d;
  logic [ADDR_W-1:0]  pc_sel_d;

  // Wraps naturally from all-ones to zero.
  assign pc_plus1_d = pc_q + 1'b1;
  // PC to use for the next request when a redirect may land this cycle.
  assign pc_sel_d   = redirect ? redirect_target : pc_q;

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values; mixing in = would make results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_valid_q <= 1'b0;
      instruction_q <= '0;
      instr_pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (!imem_req_q) begin
            // Request not yet on the bus (first cycle after reset).
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_sel_d;
            pc_q        <= pc_sel_d;
          end else if (imem_ack) begin
            if (redirect) begin
              // Data belongs to the old path: drop it, request the target.
              pc_q        <= redirect_target;
              imem_addr_q <= redirect_target;
            end else begin
              instruction_q <= imem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              imem_req_q    <= 1'b0;
              state_q       <= ST_ISSUE;
            end
          end else if (redirect) begin
            // The bus request must stay stable until acked.
            pc_q    <= redirect_target;
            state_q <= ST_FLUSH;
          end
        end

        ST_ISSUE: begin
          if (redirect) begin
            // Redirect wins over a simultaneous accept.
            instr_valid_q <= 1'b0;
            pc_q          <= redirect_target;
            imem_addr_q   <= redirect_target;
            imem_req_q    <= 1'b1;
            state_q       <= ST_REQ;
          end else if (instr_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_plus1_d;
            imem_addr_q   <= pc_plus1_d;
            imem_req_q    <= 1'b1;
            state_q       <= ST_REQ;
          end
        end

        ST_FLUSH: begin
          // Latest redirect wins; the stale request keeps its old address.
          pc_q <= pc_sel_d;
          if (imem_ack) begin
            imem_addr_q <= pc_sel_d;
            state_q     <= ST_REQ;
          end
        end

        default: begin
          state_q    <= ST_REQ;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instruction = instruction_q;
  assign instr_pc    = instr_pc_q;

endmodule
